// File: rtl/peak_hold_multi.sv
// Per-window magnitude peak detector for NCH parallel channels with clip flags
// and a registered cross-channel maximum; window length set by an internal counter.
module peak_hold_multi #(
   parameter int unsigned W      = 32,
   parameter int unsigned NCH    = 4,
   parameter int unsigned PERIOD = 150000,
   parameter bit          SIGNED = 1'b1
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [NCH*W-1:0]                          din,
   input  logic                                      din_valid,
   output logic [NCH*W-1:0]                          peak,
   output logic                                      peak_valid,
   output logic [NCH-1:0]                            clip,
   output logic [W-1:0]                              gmax,
   output logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0]    gidx,
   output logic                                      gvalid
);

   localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
   localparam logic [W-1:0]  FS   = SIGNED ? {1'b0, {(W-1){1'b1}}} : {W{1'b1}};

   logic [CW-1:0]  cnt;
   logic           tick_q;
   logic           vld_q;
   logic [W-1:0]   mag_d   [NCH];
   logic [W-1:0]   mag_q   [NCH];
   logic [W-1:0]   inner   [NCH];
   logic [W-1:0]   acc_max [NCH];
   logic [NCH-1:0] clip_acc;
   logic [NCH-1:0] acc_clip;
   logic [W-1:0]   lane_max;
   logic [IW-1:0]  lane_idx;

   // Ones'-complement magnitude; invalid samples become zero.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         mag_d[c] = '0;
         if (din_valid) begin
            if (SIGNED && din[c*W + W - 1])
               mag_d[c] = {1'b0, ~din[c*W +: W-1]};
            else
               mag_d[c] = din[c*W +: W];
         end
      end
   end

   // Running max and clip including the sample currently in the magnitude stage.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         acc_max[c]  = (vld_q && (mag_q[c] > inner[c])) ? mag_q[c] : inner[c];
         acc_clip[c] = clip_acc[c] | (vld_q && (mag_q[c] == FS));
      end
   end

   // Cross-lane maximum; strict compare keeps the lowest index on ties.
   always_comb begin
      lane_max = peak[0 +: W];
      lane_idx = '0;
      for (int c = 1; c < NCH; c++) begin
         if (peak[c*W +: W] > lane_max) begin
            lane_max = peak[c*W +: W];
            lane_idx = IW'(c);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         tick_q     <= 1'b0;
         vld_q      <= 1'b0;
         clip_acc   <= '0;
         peak       <= '0;
         clip       <= '0;
         peak_valid <= 1'b0;
         gmax       <= '0;
         gidx       <= '0;
         gvalid     <= 1'b0;
         for (int c = 0; c < NCH; c++) begin
            mag_q[c] <= '0;
            inner[c] <= '0;
         end
      end else begin
         cnt        <= (cnt == LAST) ? '0 : cnt + CW'(1);
         tick_q     <= (cnt == LAST);
         vld_q      <= din_valid;
         peak_valid <= tick_q;
         gvalid     <= peak_valid;
         for (int c = 0; c < NCH; c++)
            mag_q[c] <= mag_d[c];

         // Window close folds in the last sample and restarts the accumulators.
         if (tick_q) begin
            for (int c = 0; c < NCH; c++) begin
               peak[c*W +: W] <= acc_max[c];
               inner[c]       <= '0;
            end
            clip     <= acc_clip;
            clip_acc <= '0;
         end else begin
            for (int c = 0; c < NCH; c++)
               inner[c] <= acc_max[c];
            clip_acc <= acc_clip;
         end

         if (peak_valid) begin
            gmax <= lane_max;
            gidx <= lane_idx;
         end
      end
   end

endmodule

// File: tb/tb_peak_hold_multi.sv
// Self-checking bench for peak_hold_multi (W=16, NCH=4, PERIOD=16) with a
// window model feeding a scoreboard queue, plus an unsigned instance.
module tb_peak_hold_multi;

   typedef struct packed {
      logic [63:0] peak;
      logic [3:0]  clip;
      logic [15:0] gmax;
      logic [1:0]  gidx;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] din = '0;
   logic        din_valid = 1'b0;

   logic [63:0] peak, peak_u;
   logic        peak_valid, peak_valid_u;
   logic [3:0]  clip, clip_u;
   logic [15:0] gmax, gmax_u;
   logic [1:0]  gidx, gidx_u;
   logic        gvalid, gvalid_u;

   int n_chk = 0;
   int n_fail = 0;

   exp_t        sb [$];
   logic [15:0] m_peak [4];
   logic [3:0]  m_clip;
   int          m_phase;

   always #5 clk = ~clk;

   peak_hold_multi #(.W(16), .NCH(4), .PERIOD(16), .SIGNED(1'b1)) u_dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .peak(peak), .peak_valid(peak_valid), .clip(clip),
      .gmax(gmax), .gidx(gidx), .gvalid(gvalid));

   peak_hold_multi #(.W(16), .NCH(4), .PERIOD(16), .SIGNED(1'b0)) u_uns (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .peak(peak_u), .peak_valid(peak_valid_u), .clip(clip_u),
      .gmax(gmax_u), .gidx(gidx_u), .gvalid(gvalid_u));

   function automatic logic [15:0] mag_s(input logic [15:0] x);
      return x[15] ? {1'b0, ~x[14:0]} : x;
   endfunction

   task automatic clear_model();
      for (int c = 0; c < 4; c++) m_peak[c] = '0;
      m_clip  = '0;
      m_phase = 0;
      sb.delete();
   endtask

   // Present one sample set for the next edge; pushes expectations at window end.
   task automatic drive(input logic [63:0] d, input logic v);
      logic [15:0] m;
      exp_t        e;
      din       = d;
      din_valid = v;
      for (int c = 0; c < 4; c++) begin
         m = v ? mag_s(d[c*16 +: 16]) : 16'd0;
         if (m > m_peak[c]) m_peak[c] = m;
         if (v && m == 16'h7FFF) m_clip[c] = 1'b1;
      end
      m_phase++;
      if (m_phase == 16) begin
         e.peak = {m_peak[3], m_peak[2], m_peak[1], m_peak[0]};
         e.clip = m_clip;
         e.gmax = m_peak[0];
         e.gidx = 2'd0;
         for (int c = 1; c < 4; c++)
            if (m_peak[c] > e.gmax) begin
               e.gmax = m_peak[c];
               e.gidx = 2'(c);
            end
         sb.push_back(e);
         for (int c = 0; c < 4; c++) m_peak[c] = '0;
         m_clip  = '0;
         m_phase = 0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // Leaves the bench at a negedge with rst low; the next edge is edge 1.
   task automatic do_reset();
      rst       = 1'b1;
      din       = '0;
      din_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_model();
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      din       = '1;
      din_valid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({peak, clip, gmax, gidx, peak_valid, gvalid} !== 88'd0) begin
         n_fail++;
         $display("FAIL reset_signed: got peak=%h clip=%b gmax=%h gidx=%0d pv=%b gv=%b expected all 0",
                  peak, clip, gmax, gidx, peak_valid, gvalid);
      end
      n_chk++;
      if ({peak_u, clip_u, gmax_u, gidx_u, peak_valid_u, gvalid_u} !== 88'd0) begin
         n_fail++;
         $display("FAIL reset_unsigned: got peak=%h clip=%b gmax=%h expected all 0", peak_u, clip_u, gmax_u);
      end
   endtask

   task automatic test_basic();
      exp_t e;
      do_reset();
      repeat (16) drive({16'd0, 16'd3, 16'd7, 16'hFFFB}, 1'b1);
      drive('0, 1'b0);
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      n_chk++;
      if ({peak_valid, peak, clip} !== {1'b1, e.peak, e.clip}) begin
         n_fail++;
         $display("FAIL basic_close: got pv=%b peak=%h clip=%b expected pv=1 peak=%h clip=%b",
                  peak_valid, peak, clip, e.peak, e.clip);
      end
      drive('0, 1'b0);
      n_chk++;
      if ({gvalid, peak_valid, gmax, gidx} !== {1'b1, 1'b0, e.gmax, e.gidx}) begin
         n_fail++;
         $display("FAIL basic_global: got gv=%b pv=%b gmax=%h gidx=%0d expected gv=1 pv=0 gmax=%h gidx=%0d",
                  gvalid, peak_valid, gmax, gidx, e.gmax, e.gidx);
      end
   endtask

   task automatic test_clip_boundary();
      exp_t e;
      do_reset();
      repeat (15) drive('0, 1'b1);
      drive({48'd0, 16'h7FFF}, 1'b1);
      drive('0, 1'b1);
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      n_chk++;
      if ({peak_valid, peak, clip} !== {1'b1, e.peak, e.clip}) begin
         n_fail++;
         $display("FAIL boundary_close: got pv=%b peak=%h clip=%b expected pv=1 peak=%h clip=%b",
                  peak_valid, peak, clip, e.peak, e.clip);
      end
      drive('0, 1'b1);
      n_chk++;
      if ({gvalid, peak_valid, gmax, gidx} !== {1'b1, 1'b0, e.gmax, e.gidx}) begin
         n_fail++;
         $display("FAIL boundary_global: got gv=%b pv=%b gmax=%h gidx=%0d expected gmax=%h gidx=%0d",
                  gvalid, peak_valid, gmax, gidx, e.gmax, e.gidx);
      end
      repeat (7) drive('0, 1'b1);
      n_chk++;
      if ({peak_valid, gvalid, peak, clip} !== {1'b0, 1'b0, e.peak, e.clip}) begin
         n_fail++;
         $display("FAIL boundary_hold: got pv=%b gv=%b peak=%h clip=%b expected pv=0 gv=0 peak=%h clip=%b",
                  peak_valid, gvalid, peak, clip, e.peak, e.clip);
      end
      repeat (7) drive('0, 1'b1);
      drive('0, 1'b1);
      e = (sb.size() != 0) ? sb.pop_front() : '1;
      n_chk++;
      if ({peak_valid, peak, clip} !== {1'b1, e.peak, e.clip}) begin
         n_fail++;
         $display("FAIL boundary_next: got pv=%b peak=%h clip=%b expected pv=1 peak=%h clip=%b",
                  peak_valid, peak, clip, e.peak, e.clip);
      end
   endtask

   task automatic test_signed_extremes();
      exp_t e;
      do_reset();
      repeat (5) drive({16'd0, 16'd9, 16'd0, 16'd2}, 1'b1);
      drive({16'd0, 16'hFFFF, 16'h8000, 16'd2}, 1'b1);
      repeat (10) drive({16'd0, 16'd0, 16'd0, 16'd2}, 1'b1);
      drive('0, 1'b0);
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      n_chk++;
      if ({peak_valid, peak, clip} !== {1'b1, e.peak, e.clip}) begin
         n_fail++;
         $display("FAIL extremes_close: got pv=%b peak=%h clip=%b expected pv=1 peak=%h clip=%b",
                  peak_valid, peak, clip, e.peak, e.clip);
      end
      drive('0, 1'b0);
      n_chk++;
      if ({gvalid, gmax, gidx} !== {1'b1, e.gmax, e.gidx}) begin
         n_fail++;
         $display("FAIL extremes_global: got gv=%b gmax=%h gidx=%0d expected gmax=%h gidx=%0d",
                  gvalid, gmax, gidx, e.gmax, e.gidx);
      end
   endtask

   task automatic test_invalid();
      exp_t e;
      do_reset();
      repeat (16) drive({48'd0, 16'h1234}, 1'b0);
      drive('0, 1'b0);
      e = (sb.size() != 0) ? sb.pop_front() : '1;
      n_chk++;
      if ({peak_valid, peak, clip} !== {1'b1, e.peak, e.clip}) begin
         n_fail++;
         $display("FAIL invalid_close: got pv=%b peak=%h clip=%b expected pv=1 peak=%h clip=%b",
                  peak_valid, peak, clip, e.peak, e.clip);
      end
      drive('0, 1'b0);
      n_chk++;
      if ({gvalid, peak_valid, gmax, gidx} !== {1'b1, 1'b0, e.gmax, e.gidx}) begin
         n_fail++;
         $display("FAIL invalid_global: got gv=%b pv=%b gmax=%h gidx=%0d expected gv=1 gmax=%h gidx=%0d",
                  gvalid, peak_valid, gmax, gidx, e.gmax, e.gidx);
      end
   endtask

   task automatic test_ties();
      exp_t e;
      do_reset();
      repeat (16) drive({16'd100, 16'd100, 16'd50, 16'd50}, 1'b1);
      drive('0, 1'b1);
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      n_chk++;
      if ({peak_valid, gvalid, peak} !== {1'b1, 1'b0, e.peak}) begin
         n_fail++;
         $display("FAIL ties_close: got pv=%b gv=%b peak=%h expected pv=1 gv=0 peak=%h",
                  peak_valid, gvalid, peak, e.peak);
      end
      drive('0, 1'b1);
      n_chk++;
      if ({gvalid, peak_valid, gmax, gidx} !== {1'b1, 1'b0, e.gmax, e.gidx}) begin
         n_fail++;
         $display("FAIL ties_global: got gv=%b pv=%b gmax=%0d gidx=%0d expected gmax=%0d gidx=%0d",
                  gvalid, peak_valid, gmax, gidx, e.gmax, e.gidx);
      end
      drive('0, 1'b1);
      n_chk++;
      if (gvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL ties_gvalid_pulse: got gv=%b expected 0", gvalid);
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      int   early;
      do_reset();
      repeat (8) drive({4{16'h7000}}, 1'b1);
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      n_chk++;
      if ({peak, clip, gmax, gidx, peak_valid, gvalid} !== 88'd0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got peak=%h clip=%b gmax=%h pv=%b gv=%b expected all 0",
                  peak, clip, gmax, peak_valid, gvalid);
      end
      rst = 1'b0;
      clear_model();
      early = 0;
      repeat (16) begin
         drive({16'd4, 16'd3, 16'd2, 16'd1}, 1'b1);
         if (peak_valid !== 1'b0 || gvalid !== 1'b0) early++;
      end
      n_chk++;
      if (early != 0) begin
         n_fail++;
         $display("FAIL midreset_early: got %0d early valid cycles expected 0", early);
      end
      drive('0, 1'b0);
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      n_chk++;
      if ({peak_valid, peak, clip} !== {1'b1, e.peak, e.clip}) begin
         n_fail++;
         $display("FAIL midreset_close: got pv=%b peak=%h clip=%b expected pv=1 peak=%h clip=%b",
                  peak_valid, peak, clip, e.peak, e.clip);
      end
      drive('0, 1'b0);
      n_chk++;
      if ({gvalid, gmax, gidx} !== {1'b1, e.gmax, e.gidx}) begin
         n_fail++;
         $display("FAIL midreset_global: got gv=%b gmax=%h gidx=%0d expected gmax=%h gidx=%0d",
                  gvalid, gmax, gidx, e.gmax, e.gidx);
      end
   endtask

   task automatic test_unsigned();
      exp_t e;
      do_reset();
      repeat (16) drive({48'd0, 16'hFFFF}, 1'b1);
      drive('0, 1'b0);
      e = (sb.size() != 0) ? sb.pop_front() : '1;
      n_chk++;
      if ({peak_valid, peak, clip} !== {1'b1, e.peak, e.clip}) begin
         n_fail++;
         $display("FAIL unsigned_signed_lane: got pv=%b peak=%h clip=%b expected pv=1 peak=%h clip=%b",
                  peak_valid, peak, clip, e.peak, e.clip);
      end
      n_chk++;
      if ({peak_valid_u, peak_u, clip_u} !== {1'b1, 48'd0, 16'hFFFF, 4'b0001}) begin
         n_fail++;
         $display("FAIL unsigned_close: got pv=%b peak=%h clip=%b expected pv=1 peak=000000000000ffff clip=0001",
                  peak_valid_u, peak_u, clip_u);
      end
      drive('0, 1'b0);
      n_chk++;
      if ({gvalid_u, gmax_u, gidx_u} !== {1'b1, 16'hFFFF, 2'd0}) begin
         n_fail++;
         $display("FAIL unsigned_global: got gv=%b gmax=%h gidx=%0d expected gv=1 gmax=ffff gidx=0",
                  gvalid_u, gmax_u, gidx_u);
      end
   endtask

   initial begin
      clear_model();
      test_reset();
      test_basic();
      test_clip_boundary();
      test_signed_extremes();
      test_invalid();
      test_ties();
      test_mid_reset();
      test_unsigned();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
